sr_chain_loader: RTL and testbench
==================================

SR_CHAIN_LOADER -- requirements
Module: sr_chain_loader

Interface
REQ-001 Parameter STAT_W, default 88, static chain length in bits (>=1).
REQ-002 Parameter DYN_W, default 16, dynamic chain length in bits (>=1).
REQ-003 Parameter DIV_HALF, default 2, CLK cycles per SCLK half-period (>=1).
REQ-004 CLK  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one load sequence, sampled in IDLE only.
REQ-007 with_stat  input  1  sampled with start: 1 = static chain then dynamic chain, 0 = dynamic chain only.
REQ-008 abort  input  1  synchronous cancel of the sequence in progress.
REQ-009 stat_data  input  STAT_W  static chain image, captured on start acceptance.
REQ-010 dyn_data  input  DYN_W  dynamic chain image, captured on start acceptance.
REQ-011 busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-012 done  output  1  one-cycle pulse on completion without abort.
REQ-013 sclk  output  1  serial shift clock to both chains.
REQ-014 sdo  output  1  serial data, MSB first.
REQ-015 stat_latch / dyn_latch  output  1 each  latch strobes for the static and dynamic chains.

Function
REQ-016 The FSM SHALL have the states IDLE, SH_STAT, LAT_STAT, SH_DYN, LAT_DYN and DONE.
REQ-017 In IDLE, start=1 SHALL capture both data ports and with_stat, then go to SH_STAT (with_stat=1) or SH_DYN (with_stat=0).
REQ-018 Each bit period SHALL be 2*DIV_HALF cycles: sclk low for the first DIV_HALF cycles and high for the next DIV_HALF; sdo SHALL change only at bit-period start.
REQ-019 SH_STAT SHALL shift STAT_W bits and SH_DYN SHALL shift DYN_W bits, MSB first; the bit counter SHALL be sized $clog2(max(STAT_W,DYN_W))+1.
REQ-020 LAT_STAT SHALL assert stat_latch, and LAT_DYN SHALL assert dyn_latch, for exactly DIV_HALF cycles with sclk low; the next states are SH_DYN and DONE respectively.
REQ-021 DONE SHALL last 1 cycle with done=1, then go to IDLE; busy SHALL be low in that IDLE cycle.
REQ-022 start during busy SHALL be ignored; new data SHALL be accepted no earlier than the cycle after done.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with sclk=0, sdo=0 and no latch or done pulse; if abort=1 coincides with start in IDLE, no sequence SHALL be accepted.
REQ-024 Latency with with_stat=1 SHALL be (STAT_W+DYN_W)*2*DIV_HALF + 2*DIV_HALF + 1 cycles from the acceptance edge to the done edge; with with_stat=0 it SHALL be DYN_W*2*DIV_HALF + DIV_HALF + 1 cycles.

Reset
REQ-025 While RST_N=0: state=IDLE and busy, done, sclk, sdo, stat_latch, dyn_latch = 0; shift registers and counters = 0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no latch pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-027 Macro SR_CHAIN_READBACK_EN: when defined, the block SHALL add input sdi (1 bit), sampled on each sclk rising edge, and outputs rb_data (STAT_W+DYN_W bits) and rb_mismatch (1 bit).
REQ-028 With SR_CHAIN_READBACK_EN defined, at done rb_mismatch SHALL be 1 if the bits returned via sdi differ from the bits shifted out one full sequence earlier; it SHALL be cleared on start acceptance and on reset.
REQ-029 Without SR_CHAIN_READBACK_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package sr_chain_pkg SHALL hold the state enum type and the default STAT_W, DYN_W and DIV_HALF constants.
REQ-031 Sub-module sr_bit_timer SHALL hold the DIV_HALF divider and produce the bit_start, sclk_rise and phase_end strobes; the FSM and shifter stay in sr_chain_loader.

Verification
REQ-032 Defaults, with_stat=1, stat=88'hABCDEF123456789ABCDEF1, dyn=16'h1234 -> 104 sdo bits MSB first, stat_latch 2 cycles then dyn_latch 2 cycles, done 421 cycles after acceptance.
REQ-033 with_stat=0, dyn=16'h1234 -> no stat_latch, 16 bits 0001001000110100, done 67 cycles after acceptance.
REQ-034 start pulsed at cycle 100 of a running sequence -> ignored; a start one cycle after done -> accepted, busy high the next cycle.
REQ-035 abort at bit 40 of SH_STAT -> IDLE next cycle, sclk=0, no latch and no done; RST_N pulsed low at bit 5 of SH_DYN -> all outputs 0 immediately.
REQ-036 SR_CHAIN_READBACK_EN defined, sdi looped through a 104-bit delay, two identical sequences -> second done with rb_mismatch=0; one flipped sdi bit -> rb_mismatch=1.
REQ-037 STAT_W=1, DYN_W=1, DIV_HALF=1 -> done 7 cycles after acceptance; DIV_HALF=5 -> each sclk high phase exactly 5 cycles.

Source files
------------

// File: rtl/sr_chain_pkg.sv
// sr_chain_pkg: state encoding and default chain geometry for sr_chain_loader.
// Optional readback hardware in the loader is enabled by SR_CHAIN_READBACK_EN.
package sr_chain_pkg;

   localparam int STAT_W_DEF   = 88;
   localparam int DYN_W_DEF    = 16;
   localparam int DIV_HALF_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SH_STAT  = 3'd1,
      ST_LAT_STAT = 3'd2,
      ST_SH_DYN   = 3'd3,
      ST_LAT_DYN  = 3'd4,
      ST_DONE     = 3'd5
   } chain_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sr_bit_timer.sv
// sr_bit_timer: divides CLK into SCLK half-phases of DIV_HALF cycles and flags
// the CLK edges that close each phase (strobes are valid in the cycle before that edge).
module sr_bit_timer #(
   parameter int DIV_HALF = 2
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic run,
   input  logic clr,
   output logic bit_start,
   output logic sclk_rise,
   output logic phase_end
);

   localparam int            CW      = $clog2(2 * DIV_HALF);
   localparam logic [CW-1:0] LAST_LO = CW'(DIV_HALF - 1);
   localparam logic [CW-1:0] LAST_HI = CW'(2 * DIV_HALF - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Position within the current bit period; held at zero while idle or on restart.
   always_comb begin
      cnt_d = cnt_q;
      if (!run || clr) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == LAST_HI) begin
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Divider counter register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // bit_start marks the edge that opens the next bit period.
   assign sclk_rise = run && (cnt_q == LAST_LO);
   assign bit_start = run && (cnt_q == LAST_HI);
   assign phase_end = sclk_rise || bit_start;

endmodule

// File: rtl/sr_chain_loader.sv
// sr_chain_loader: shifts a static and/or dynamic chain image out MSB first and strobes
// the chain latches. Define SR_CHAIN_READBACK_EN to add sdi loopback comparison.
module sr_chain_loader
   import sr_chain_pkg::*;
#(
   parameter int STAT_W   = STAT_W_DEF,
   parameter int DYN_W    = DYN_W_DEF,
   parameter int DIV_HALF = DIV_HALF_DEF
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    start,
   input  logic                    with_stat,
   input  logic                    abort,
   input  logic [STAT_W-1:0]       stat_data,
   input  logic [DYN_W-1:0]        dyn_data,
`ifdef SR_CHAIN_READBACK_EN
   input  logic                    sdi,
   output logic [STAT_W+DYN_W-1:0] rb_data,
   output logic                    rb_mismatch,
`endif
   output logic                    busy,
   output logic                    done,
   output logic                    sclk,
   output logic                    sdo,
   output logic                    stat_latch,
   output logic                    dyn_latch
);

   localparam int             BCW     = $clog2(max_int(STAT_W, DYN_W)) + 1;
   localparam logic [BCW-1:0] BIT_ONE = BCW'(1);

   chain_state_e      state_q, state_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [STAT_W-1:0] stat_sr_q, stat_sr_d;
   logic [DYN_W-1:0]  dyn_sr_q, dyn_sr_d;
   logic              busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, sdo_q, sdo_d;
   logic              stat_latch_q, stat_latch_d, dyn_latch_q, dyn_latch_d;
   logic              accept, tmr_run, tmr_clr, bit_start, sclk_rise, phase_end;
   logic              in_stat;

   assign accept  = (state_q == ST_IDLE) && start && !abort;
   assign tmr_run = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign in_stat = (state_q == ST_SH_STAT) || (state_q == ST_LAT_STAT);

   sr_bit_timer #(.DIV_HALF(DIV_HALF)) u_timer (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .run       (tmr_run),
      .clr       (tmr_clr),
      .bit_start (bit_start),
      .sclk_rise (sclk_rise),
      .phase_end (phase_end)
   );

   // Next state plus next output values, so every output leaves a flop.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      stat_sr_d    = stat_sr_q;
      dyn_sr_d     = dyn_sr_q;
      sclk_d       = sclk_q;
      sdo_d        = sdo_q;
      stat_latch_d = 1'b0;
      dyn_latch_d  = 1'b0;
      done_d       = 1'b0;
      tmr_clr      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sclk_d = 1'b0;
            sdo_d  = 1'b0;
            if (accept) begin
               stat_sr_d = stat_data;
               dyn_sr_d  = dyn_data;
               if (with_stat) begin
                  state_d   = ST_SH_STAT;
                  bit_cnt_d = BCW'(STAT_W);
                  sdo_d     = stat_data[STAT_W-1];
               end else begin
                  state_d   = ST_SH_DYN;
                  bit_cnt_d = BCW'(DYN_W);
                  sdo_d     = dyn_data[DYN_W-1];
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SH_STAT, ST_SH_DYN: begin
            if (sclk_rise) begin
               sclk_d = 1'b1;
            end else if (bit_start) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == BIT_ONE) begin
                  state_d      = in_stat ? ST_LAT_STAT : ST_LAT_DYN;
                  sdo_d        = 1'b0;
                  stat_latch_d = in_stat;
                  dyn_latch_d  = !in_stat;
               end else if (in_stat) begin
                  bit_cnt_d = bit_cnt_q - BIT_ONE;
                  stat_sr_d = stat_sr_q << 1;
                  sdo_d     = stat_sr_d[STAT_W-1];
               end else begin
                  bit_cnt_d = bit_cnt_q - BIT_ONE;
                  dyn_sr_d  = dyn_sr_q << 1;
                  sdo_d     = dyn_sr_d[DYN_W-1];
               end
            end else begin
               sclk_d = sclk_q;
            end
         end
         ST_LAT_STAT, ST_LAT_DYN: begin
            sclk_d = 1'b0;
            sdo_d  = 1'b0;
            if (phase_end) begin
               tmr_clr = 1'b1;
               if (in_stat) begin
                  state_d   = ST_SH_DYN;
                  bit_cnt_d = BCW'(DYN_W);
                  sdo_d     = dyn_sr_q[DYN_W-1];
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               stat_latch_d = in_stat;
               dyn_latch_d  = !in_stat;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
         end
      endcase
      // Cancel wins over everything the sequence would have done this edge.
      if (abort && (state_q != ST_IDLE)) begin
         state_d      = ST_IDLE;
         sclk_d       = 1'b0;
         sdo_d        = 1'b0;
         stat_latch_d = 1'b0;
         dyn_latch_d  = 1'b0;
         done_d       = 1'b0;
         tmr_clr      = 1'b1;
      end else begin
         tmr_clr = tmr_clr;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // Sequencer state, shifters and output flops.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= {BCW{1'b0}};
         stat_sr_q    <= {STAT_W{1'b0}};
         dyn_sr_q     <= {DYN_W{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sclk_q       <= 1'b0;
         sdo_q        <= 1'b0;
         stat_latch_q <= 1'b0;
         dyn_latch_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         stat_sr_q    <= stat_sr_d;
         dyn_sr_q     <= dyn_sr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sclk_q       <= sclk_d;
         sdo_q        <= sdo_d;
         stat_latch_q <= stat_latch_d;
         dyn_latch_q  <= dyn_latch_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign sclk       = sclk_q;
   assign sdo        = sdo_q;
   assign stat_latch = stat_latch_q;
   assign dyn_latch  = dyn_latch_q;

`ifdef SR_CHAIN_READBACK_EN
   localparam int TOT_W = STAT_W + DYN_W;

   logic [TOT_W-1:0] rb_q, rb_d, tx_q, tx_d, prev_q, prev_d;
   logic             mis_q, mis_d, smp_en;

   assign smp_en = ((state_q == ST_SH_STAT) || (state_q == ST_SH_DYN)) && sclk_rise && !abort;

   // Returned bits are judged against what the previous completed sequence sent.
   always_comb begin
      rb_d   = rb_q;
      tx_d   = tx_q;
      prev_d = prev_q;
      mis_d  = mis_q;
      if (accept) begin
         rb_d  = {TOT_W{1'b0}};
         tx_d  = {TOT_W{1'b0}};
         mis_d = 1'b0;
      end else if (smp_en) begin
         rb_d = {rb_q[TOT_W-2:0], sdi};
         tx_d = {tx_q[TOT_W-2:0], sdo_q};
      end else if (done_d) begin
         mis_d  = (rb_q != prev_q);
         prev_d = tx_q;
      end else begin
         mis_d = mis_q;
      end
   end

   // Readback capture registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rb_q   <= {TOT_W{1'b0}};
         tx_q   <= {TOT_W{1'b0}};
         prev_q <= {TOT_W{1'b0}};
         mis_q  <= 1'b0;
      end else begin
         rb_q   <= rb_d;
         tx_q   <= tx_d;
         prev_q <= prev_d;
         mis_q  <= mis_d;
      end
   end

   assign rb_data     = rb_q;
   assign rb_mismatch = mis_q;
`endif

endmodule

// File: tb/tb_sr_chain_loader.sv
// tb_sr_chain_loader: directed checks of sr_chain_loader at default, minimum and
// slow-divider settings; readback checks are added when SR_CHAIN_READBACK_EN is defined.
module tb_sr_chain_loader;

   localparam logic [87:0] STAT_IMG = 88'hABCDEF123456789ABCDEF1;
   localparam logic [15:0] DYN_IMG  = 16'h1234;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        start, with_stat, abort;
   logic [87:0] stat_data;
   logic [15:0] dyn_data;
   int          sel;
   logic [2:0]  start_v;
   logic [5:0]  o0, o1, o2, m;

   int n_chk = 0;
   int n_pass = 0;

   int          cyc_done, nbits, n_stat, n_dyn, stat_last, dyn_first, lat_viol, sdo_viol;
   int          hi_min, hi_max;
   logic [127:0] rx;
   logic [5:0]  snap;
   logic        busy1;

   always #5 CLK = ~CLK;

   assign start_v = {start && (sel == 2), start && (sel == 1), start && (sel == 0)};
   // m = {busy, done, sclk, sdo, stat_latch, dyn_latch} of the selected instance
   assign m = (sel == 0) ? o0 : ((sel == 1) ? o1 : o2);

`ifdef SR_CHAIN_READBACK_EN
   logic [103:0] rb0, rb2;
   logic [1:0]   rb1;
   logic         rbm0, rbm1, rbm2, sdi0, flip_en;
   logic [103:0] dl = 104'h0;
   int           rb_cnt = 0;
   int           flip_at;

   always @(posedge o0[3]) begin
      dl     <= {dl[102:0], o0[2]};
      rb_cnt <= rb_cnt + 1;
   end
   assign sdi0 = dl[103] ^ (flip_en && (rb_cnt == flip_at));
`endif

   sr_chain_loader u_dut (
      .CLK(CLK), .RST_N(RST_N), .start(start_v[0]), .with_stat(with_stat), .abort(abort),
      .stat_data(stat_data), .dyn_data(dyn_data),
`ifdef SR_CHAIN_READBACK_EN
      .sdi(sdi0), .rb_data(rb0), .rb_mismatch(rbm0),
`endif
      .busy(o0[5]), .done(o0[4]), .sclk(o0[3]), .sdo(o0[2]),
      .stat_latch(o0[1]), .dyn_latch(o0[0])
   );

   sr_chain_loader #(.STAT_W(1), .DYN_W(1), .DIV_HALF(1)) u_min (
      .CLK(CLK), .RST_N(RST_N), .start(start_v[1]), .with_stat(with_stat), .abort(abort),
      .stat_data(stat_data[0]), .dyn_data(dyn_data[0]),
`ifdef SR_CHAIN_READBACK_EN
      .sdi(1'b0), .rb_data(rb1), .rb_mismatch(rbm1),
`endif
      .busy(o1[5]), .done(o1[4]), .sclk(o1[3]), .sdo(o1[2]),
      .stat_latch(o1[1]), .dyn_latch(o1[0])
   );

   sr_chain_loader #(.DIV_HALF(5)) u_div5 (
      .CLK(CLK), .RST_N(RST_N), .start(start_v[2]), .with_stat(with_stat), .abort(abort),
      .stat_data(stat_data), .dyn_data(dyn_data),
`ifdef SR_CHAIN_READBACK_EN
      .sdi(1'b0), .rb_data(rb2), .rb_mismatch(rbm2),
`endif
      .busy(o2[5]), .done(o2[4]), .sclk(o2[3]), .sdo(o2[2]),
      .stat_latch(o2[1]), .dyn_latch(o2[0])
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the first negedge after acceptance (cycle 1).
   task automatic start_seq(input logic ws, input logic [87:0] sd, input logic [15:0] dd);
      with_stat = ws;
      stat_data = sd;
      dyn_data  = dd;
      start     = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Observe the selected instance until done or max_cyc; inj_kind 1 = start pulse, 2 = abort.
   task automatic watch(input int max_cyc, input int inj_cyc, input int inj_kind);
      int          cyc;
      int          hi_run;
      logic        sclk_p, sdo_p;
      logic [87:0] keep;
      cyc = 1; cyc_done = 0; nbits = 0; rx = 128'h0; n_stat = 0; n_dyn = 0;
      stat_last = 0; dyn_first = 0; lat_viol = 0; sdo_viol = 0;
      hi_min = 1000; hi_max = 0; hi_run = 0; snap = 6'h3f;
      busy1  = m[5];
      sclk_p = m[3];
      sdo_p  = m[2];
      keep   = stat_data;
      while (cyc_done == 0 && cyc < max_cyc) begin
         if (cyc == inj_cyc && inj_kind == 1) begin
            start     = 1'b1;
            stat_data = ~keep;
         end
         if (cyc == inj_cyc && inj_kind == 2) abort = 1'b1;
         @(negedge CLK);
         cyc++;
         start     = 1'b0;
         abort     = 1'b0;
         stat_data = keep;
         if (cyc == inj_cyc + 1) snap = m;
         if (m[3] && !sclk_p) begin
            rx = {rx[126:0], m[2]};
            nbits++;
         end
         if (m[3]) begin
            hi_run++;
         end else begin
            if (hi_run > 0) begin
               hi_min = (hi_run < hi_min) ? hi_run : hi_min;
               hi_max = (hi_run > hi_max) ? hi_run : hi_max;
            end
            hi_run = 0;
         end
         if (m[3] && (m[2] !== sdo_p)) sdo_viol++;
         if (m[1]) begin
            n_stat++;
            stat_last = cyc;
         end
         if (m[0]) begin
            n_dyn++;
            if (dyn_first == 0) dyn_first = cyc;
         end
         if ((m[1] || m[0]) && m[3]) lat_viol++;
         if (m[4]) cyc_done = cyc;
         sclk_p = m[3];
         sdo_p  = m[2];
      end
   endtask

   initial begin
      RST_N = 1'b0; start = 1'b0; abort = 1'b0; with_stat = 1'b0;
      stat_data = 88'h0; dyn_data = 16'h0; sel = 0;
`ifdef SR_CHAIN_READBACK_EN
      flip_en = 1'b0; flip_at = -1;
`endif
      repeat (3) @(negedge CLK);
      chk("reset_outs", {o0, o1, o2}, 18'h0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Full sequence with a start pulse at cycle 100 that must be ignored.
      start_seq(1'b1, STAT_IMG, DYN_IMG);
      watch(600, 100, 1);
      chk("a_busy", busy1, 1'b1);
      chk("a_latency", cyc_done, 421);
      chk("a_nbits", nbits, 104);
      chk("a_data", rx, {STAT_IMG, DYN_IMG});
      chk("a_stat_latch_len", n_stat, 2);
      chk("a_dyn_latch_len", n_dyn, 2);
      chk("a_latch_order", stat_last < dyn_first, 1'b1);
      chk("a_latch_sclk", lat_viol, 0);
      chk("a_sdo_stable", sdo_viol, 0);
      chk("a_hi_min", hi_min, 2);
      chk("a_hi_max", hi_max, 2);
      @(negedge CLK);
      chk("a_idle_after_done", m[5:4], 2'b00);

      // Dynamic-only sequence started one cycle after the previous done.
      start_seq(1'b0, STAT_IMG, DYN_IMG);
      watch(200, 0, 0);
      chk("b_restart_busy", busy1, 1'b1);
      chk("b_latency", cyc_done, 67);
      chk("b_nbits", nbits, 16);
      chk("b_data", rx, 128'h1234);
      chk("b_no_stat_latch", n_stat, 0);
      chk("b_dyn_latch_len", n_dyn, 2);

      // Abort at the start of static bit 40.
      @(negedge CLK);
      start_seq(1'b1, STAT_IMG, DYN_IMG);
      watch(450, 161, 2);
      chk("c_abort_outs", snap, 6'h00);
      chk("c_abort_nbits", nbits, 40);
      chk("c_abort_data", rx, 128'hABCDEF1234);
      chk("c_abort_no_latch", n_stat + n_dyn, 0);
      chk("c_abort_no_done", cyc_done, 0);

      // Abort together with start in IDLE accepts nothing.
      start = 1'b1;
      abort = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      abort = 1'b0;
      chk("d_abort_start_idle", m[5], 1'b0);

      // Reset in dynamic bit 5, then a normal sequence.
      @(negedge CLK);
      start_seq(1'b0, STAT_IMG, DYN_IMG);
      repeat (20) @(negedge CLK);
      #1;
      RST_N = 1'b0;
      #1;
      chk("e_reset_outs", m, 6'h00);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      start_seq(1'b0, STAT_IMG, 16'hC35A);
      watch(200, 0, 0);
      chk("e_post_reset_latency", cyc_done, 67);
      chk("e_post_reset_data", rx, 128'hC35A);
      chk("e_post_reset_latch", n_dyn, 2);

`ifdef SR_CHAIN_READBACK_EN
      @(negedge CLK);
      start_seq(1'b1, STAT_IMG, DYN_IMG);
      watch(600, 0, 0);
      @(negedge CLK);
      start_seq(1'b1, STAT_IMG, DYN_IMG);
      watch(600, 0, 0);
      chk("rb_match", rbm0, 1'b0);
      chk("rb_data", rb0, {STAT_IMG, DYN_IMG});
      @(negedge CLK);
      flip_at = rb_cnt + 50;
      flip_en = 1'b1;
      start_seq(1'b1, STAT_IMG, DYN_IMG);
      watch(600, 0, 0);
      chk("rb_flip", rbm0, 1'b1);
      flip_en = 1'b0;
`endif

      // Minimum geometry instance: one static bit 1, one dynamic bit 0.
      @(negedge CLK);
      sel = 1;
      start_seq(1'b1, 88'h1, 16'h0);
      watch(50, 0, 0);
      chk("f_min_latency", cyc_done, 7);
      chk("f_min_data", rx, 128'h2);
      chk("f_min_latches", {n_stat, n_dyn}, {32'd1, 32'd1});
      chk("f_min_hi", hi_max, 1);

      // Slow divider instance.
      @(negedge CLK);
      sel = 2;
      start_seq(1'b0, STAT_IMG, DYN_IMG);
      watch(400, 0, 0);
      chk("g_div5_latency", cyc_done, 166);
      chk("g_div5_hi_min", hi_min, 5);
      chk("g_div5_hi_max", hi_max, 5);
      chk("g_div5_data", rx, 128'h1234);
      chk("g_div5_latch_len", n_dyn, 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
